// File: rtl/mem_responder_if.sv
// Bus bundle between the CPU harness and mem_responder.
// Handshakes (load and dump streams): a word moves on a rising clock edge
// only when valid and ready are both 1. The source holds valid and the
// payload stable until that edge. The sink may change ready at any time.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 8
);
  // CPU memory bus
  logic [ADDR_WIDTH-1:0] mem_addr_i;
  logic [15:0]           mem_value_i;
  logic                  mem_enable_i;
  logic                  mem_wr_en_i;
  logic                  mem_rd_en_i;
  logic [15:0]           mem_value_o;
  logic                  end_program_i;
  // program-load stream
  logic                  load_valid_i;
  logic [15:0]           load_data_i;
  logic                  load_last_i;
  logic                  load_ready_o;
  logic                  cpu_rst_o;
  // result-dump stream
  logic                  dump_valid_o;
  logic [ADDR_WIDTH-1:0] dump_addr_o;
  logic [15:0]           dump_data_o;
  logic                  dump_ready_i;
  logic                  dump_done_o;
  logic                  err_o;

  // responder side (the memory)
  modport slave (
    input  mem_addr_i, mem_value_i, mem_enable_i, mem_wr_en_i, mem_rd_en_i,
    input  end_program_i, load_valid_i, load_data_i, load_last_i, dump_ready_i,
    output mem_value_o, load_ready_o, cpu_rst_o, dump_valid_o, dump_addr_o,
    output dump_data_o, dump_done_o, err_o
  );

  // requester side (CPU harness / testbench)
  modport master (
    output mem_addr_i, mem_value_i, mem_enable_i, mem_wr_en_i, mem_rd_en_i,
    output end_program_i, load_valid_i, load_data_i, load_last_i, dump_ready_i,
    input  mem_value_o, load_ready_o, cpu_rst_o, dump_valid_o, dump_addr_o,
    input  dump_data_o, dump_done_o, err_o
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port 16-bit word memory acting as the CPU's memory responder.
// Phases: LOAD (stream program in, CPU held in reset), RUN (CPU accesses),
// DUMP (stream a window of memory out), DONE (idle until reset).
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_WORDS = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_responder_if.slave bus,
  output logic [1:0]     state_dbg_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(DUMP_BASE);
  // handshake count at which the final dump word is accepted
  localparam logic [ADDR_WIDTH:0]   LAST_CNT  = (ADDR_WIDTH+1)'(DUMP_WORDS - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] load_ptr_q;
  logic [ADDR_WIDTH-1:0] dump_ptr_q;
  logic [ADDR_WIDTH:0]   dump_cnt_q;
  logic [15:0]           mem_value_q;
  logic                  load_ready_q;
  logic                  cpu_rst_q;
  logic                  dump_valid_q;
  logic [ADDR_WIDTH-1:0] dump_addr_q;
  logic [15:0]           dump_data_q;
  logic                  dump_done_q;
  logic                  err_q;

  logic [15:0] mem_q [DEPTH];

  logic                  load_acc;
  logic                  load_exit;
  logic                  run_wr;
  logic                  run_rd;
  logic                  run_err;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [15:0]           mem_wdata;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [15:0]           mem_rdata;
  logic [ADDR_WIDTH-1:0] load_ptr_d;
  logic [ADDR_WIDTH-1:0] dump_ptr_d;
  logic [ADDR_WIDTH:0]   dump_cnt_d;

  // Access decode: who writes the array this cycle, and which address is read.
  always_comb begin
    load_acc   = (state_q == S_LOAD) && bus.load_valid_i && load_ready_q;
    load_exit  = load_acc && (bus.load_last_i || (load_ptr_q == ADDR_MAX));
    // write wins over read when both strobes are up; the read is dropped
    run_wr     = (state_q == S_RUN) && bus.mem_enable_i && bus.mem_wr_en_i;
    run_rd     = (state_q == S_RUN) && bus.mem_enable_i && bus.mem_rd_en_i
                 && !bus.mem_wr_en_i;
    run_err    = (state_q == S_RUN) &&
                 ((bus.mem_rd_en_i && bus.mem_wr_en_i) ||
                  ((bus.mem_rd_en_i || bus.mem_wr_en_i) && !bus.mem_enable_i));
    mem_we     = !rst_i && (load_acc || run_wr);
    mem_waddr  = load_acc ? load_ptr_q : bus.mem_addr_i;
    mem_wdata  = load_acc ? bus.load_data_i : bus.mem_value_i;
    mem_raddr  = (state_q == S_DUMP) ? dump_ptr_q : bus.mem_addr_i;
    load_ptr_d = load_ptr_q + ADDR_WIDTH'(1);
    dump_ptr_d = dump_ptr_q + ADDR_WIDTH'(1);
    dump_cnt_d = dump_cnt_q + (ADDR_WIDTH+1)'(1);
  end

  assign mem_rdata = mem_q[mem_raddr];

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Phase FSM with all bus outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_LOAD;
      load_ptr_q   <= '0;
      dump_ptr_q   <= '0;
      dump_cnt_q   <= '0;
      mem_value_q  <= '0;
      load_ready_q <= 1'b0;
      cpu_rst_q    <= 1'b1;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      dump_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (run_err) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        S_LOAD: begin
          load_ready_q <= 1'b1;
          if (load_acc) begin
            load_ptr_q <= load_ptr_d;
            // the top address ends the load: the pointer never wraps
            if (load_exit) begin
              state_q      <= S_RUN;
              load_ready_q <= 1'b0;
              cpu_rst_q    <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (run_rd) begin
            mem_value_q <= mem_rdata;
          end
          if (bus.end_program_i) begin
            state_q      <= S_DUMP;
            cpu_rst_q    <= 1'b1;
            dump_ptr_q   <= BASE_ADDR;
            dump_cnt_q   <= '0;
            dump_valid_q <= 1'b0;
          end
        end
        S_DUMP: begin
          if (!dump_valid_q) begin
            // first word: prime the output register from the array
            dump_valid_q <= 1'b1;
            dump_addr_q  <= dump_ptr_q;
            dump_data_q  <= mem_rdata;
            dump_ptr_q   <= dump_ptr_d;
          end else if (bus.dump_ready_i) begin
            if (dump_cnt_q == LAST_CNT) begin
              dump_valid_q <= 1'b0;
              dump_done_q  <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              // next word fetched in the same edge: no bubble between words
              dump_cnt_q  <= dump_cnt_d;
              dump_addr_q <= dump_ptr_q;
              dump_data_q <= mem_rdata;
              dump_ptr_q  <= dump_ptr_d;
            end
          end
        end
        S_DONE: begin
          dump_done_q <= 1'b1;
          cpu_rst_q   <= 1'b1;
        end
        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign bus.mem_value_o  = mem_value_q;
  assign bus.load_ready_o = load_ready_q;
  assign bus.cpu_rst_o    = cpu_rst_q;
  assign bus.dump_valid_o = dump_valid_q;
  assign bus.dump_addr_o  = dump_addr_q;
  assign bus.dump_data_o  = dump_data_q;
  assign bus.dump_done_o  = dump_done_q;
  assign bus.err_o        = err_q;
  assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (dump window at 0 and at 254),
// directed phases plus randomized CPU traffic against a memory model.
module tb_mem_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a;
  logic       rst_b;
  logic [1:0] st_a;
  logic [1:0] st_b;

  mem_responder_if #(.ADDR_WIDTH(8)) if_a ();
  mem_responder_if #(.ADDR_WIDTH(8)) if_b ();

  mem_responder #(.ADDR_WIDTH(8), .DUMP_BASE(0), .DUMP_WORDS(4)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .bus(if_a.slave), .state_dbg_o(st_a)
  );

  mem_responder #(.ADDR_WIDTH(8), .DUMP_BASE(254), .DUMP_WORDS(4)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .bus(if_b.slave), .state_dbg_o(st_b)
  );

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int to_a   = 0;
  int to_b   = 0;

  logic [15:0] ref_a [256];
  logic [15:0] ref_b [256];
  logic [7:0]  lptr_a;
  logic [15:0] exp_val;
  logic        exp_err;
  logic [23:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_a();
    if_a.mem_addr_i    = '0;
    if_a.mem_value_i   = '0;
    if_a.mem_enable_i  = 1'b0;
    if_a.mem_wr_en_i   = 1'b0;
    if_a.mem_rd_en_i   = 1'b0;
    if_a.end_program_i = 1'b0;
    if_a.load_valid_i  = 1'b0;
    if_a.load_data_i   = '0;
    if_a.load_last_i   = 1'b0;
    if_a.dump_ready_i  = 1'b0;
  endtask

  task automatic idle_b();
    if_b.mem_addr_i    = '0;
    if_b.mem_value_i   = '0;
    if_b.mem_enable_i  = 1'b0;
    if_b.mem_wr_en_i   = 1'b0;
    if_b.mem_rd_en_i   = 1'b0;
    if_b.end_program_i = 1'b0;
    if_b.load_valid_i  = 1'b0;
    if_b.load_data_i   = '0;
    if_b.load_last_i   = 1'b0;
    if_b.dump_ready_i  = 1'b0;
  endtask

  // offer one load word, wait (bounded) for ready, let it be accepted
  task automatic load_a(input logic [15:0] d, input bit last);
    int w;
    if_a.load_valid_i = 1'b1;
    if_a.load_data_i  = d;
    if_a.load_last_i  = last;
    w = 0;
    while (!if_a.load_ready_o && w < 20) begin
      step();
      w++;
    end
    if (w >= 20) to_a++;
    ref_a[lptr_a] = d;
    lptr_a = lptr_a + 8'd1;
    step();
    if_a.load_valid_i = 1'b0;
    if_a.load_last_i  = 1'b0;
  endtask

  // one CPU bus cycle in RUN; model then compares read data and error flag
  task automatic cpu_op(input bit en, input bit rd, input bit wr,
                        input logic [7:0] addr, input logic [15:0] data);
    if_a.mem_enable_i = en;
    if_a.mem_rd_en_i  = rd;
    if_a.mem_wr_en_i  = wr;
    if_a.mem_addr_i   = addr;
    if_a.mem_value_i  = data;
    if (en && rd && !wr) exp_val = ref_a[addr];
    if (en && wr) ref_a[addr] = data;
    if ((rd && wr) || ((rd || wr) && !en)) exp_err = 1'b1;
    step();
    chk("run_value", if_a.mem_value_o, exp_val);
    chk("run_err", if_a.err_o, exp_err);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] held;
    logic        v;
    logic        rdy;
    logic [7:0]  a;
    logic [15:0] d;
    logic [23:0] e;
    int          hs;
    int          cyc;
    bit          tog;
    int          w;

    idle_a();
    idle_b();
    rst_a   = 1'b1;
    rst_b   = 1'b1;
    lptr_a  = 8'd0;
    exp_val = 16'h0;
    exp_err = 1'b0;
    step();
    step();

    // reset state
    chk("rst_mem_value", if_a.mem_value_o, 16'h0);
    chk("rst_load_ready", if_a.load_ready_o, 1'b0);
    chk("rst_cpu_rst", if_a.cpu_rst_o, 1'b1);
    chk("rst_dump_valid", if_a.dump_valid_o, 1'b0);
    chk("rst_dump_addr", if_a.dump_addr_o, 8'h0);
    chk("rst_dump_data", if_a.dump_data_o, 16'h0);
    chk("rst_dump_done", if_a.dump_done_o, 1'b0);
    chk("rst_err", if_a.err_o, 1'b0);

    rst_a = 1'b0;
    step();
    chk("load_ready_after_rst", if_a.load_ready_o, 1'b1);
    chk("load_cpu_rst", if_a.cpu_rst_o, 1'b1);

    // LOAD: three words with gaps; a CPU write during LOAD must be ignored
    repeat ($urandom_range(0, 2)) step();
    load_a(16'h1111, 1'b0);
    repeat ($urandom_range(1, 3)) step();
    load_a(16'h2222, 1'b0);
    if_a.mem_enable_i = 1'b1;
    if_a.mem_wr_en_i  = 1'b1;
    if_a.mem_addr_i   = 8'd1;
    if_a.mem_value_i  = 16'hDEAD;
    step();
    idle_a();
    chk("load_cpu_rst_before_last", if_a.cpu_rst_o, 1'b1);
    chk("load_ready_before_last", if_a.load_ready_o, 1'b1);
    load_a(16'h3333, 1'b1);
    chk("load_cpu_rst_fall", if_a.cpu_rst_o, 1'b0);
    chk("load_ready_drop", if_a.load_ready_o, 1'b0);
    chk("load_no_err", if_a.err_o, 1'b0);

    // RUN directed
    cpu_op(1, 1, 0, 8'd0, 16'h0);
    chk("mem0", if_a.mem_value_o, 16'h1111);
    cpu_op(1, 0, 1, 8'd5, 16'hBEEF);
    cpu_op(1, 1, 0, 8'd5, 16'h0);
    chk("raw_addr5", if_a.mem_value_o, 16'hBEEF);
    cpu_op(1, 1, 0, 8'd1, 16'h0);
    chk("mem1", if_a.mem_value_o, 16'h2222);
    cpu_op(0, 0, 0, 8'd9, 16'h0);
    chk("hold", if_a.mem_value_o, 16'h2222);
    cpu_op(1, 0, 1, 8'd3, 16'h3C3C);
    cpu_op(1, 1, 0, 8'd2, 16'h0);
    chk("mem2", if_a.mem_value_o, 16'h3333);

    // RUN random, legal traffic only
    for (int i = 16; i < 32; i++) cpu_op(1, 0, 1, 8'(i), 16'($urandom));
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: cpu_op(1'($urandom_range(0, 1)), 0, 0, 8'($urandom_range(16, 31)), 16'($urandom));
        1: cpu_op(1, 1, 0, 8'($urandom_range(16, 31)), 16'($urandom));
        default: cpu_op(1, 0, 1, 8'($urandom_range(16, 31)), 16'($urandom));
      endcase
    end
    chk("legal_no_err", if_a.err_o, 1'b0);

    // rd+wr collision
    held = exp_val;
    cpu_op(1, 1, 1, 8'd7, 16'h00AA);
    chk("collide_value_held", if_a.mem_value_o, held);
    chk("collide_err", if_a.err_o, 1'b1);
    cpu_op(1, 1, 0, 8'd7, 16'h0);
    chk("collide_write_done", if_a.mem_value_o, 16'h00AA);
    cpu_op(0, 0, 0, 8'd0, 16'h0);
    chk("err_sticky", if_a.err_o, 1'b1);

    // strobe without enable: ignored
    cpu_op(0, 0, 1, 8'd5, 16'h1234);
    cpu_op(1, 1, 0, 8'd5, 16'h0);
    chk("noen_write_ignored", if_a.mem_value_o, 16'hBEEF);
    cpu_op(0, 1, 0, 8'd1, 16'h0);
    chk("noen_read_ignored", if_a.mem_value_o, 16'hBEEF);

    // RUN random, any strobe combination
    for (int i = 0; i < 30; i++)
      cpu_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(16, 31)), 16'($urandom));

    // end of program with a same-cycle write
    if_a.end_program_i = 1'b1;
    if_a.mem_enable_i  = 1'b1;
    if_a.mem_wr_en_i   = 1'b1;
    if_a.mem_rd_en_i   = 1'b0;
    if_a.mem_addr_i    = 8'd0;
    if_a.mem_value_i   = 16'h5A5A;
    ref_a[0] = 16'h5A5A;
    step();
    // CPU write during DUMP must be ignored
    if_a.end_program_i = 1'b0;
    if_a.mem_addr_i    = 8'd1;
    if_a.mem_value_i   = 16'hFFFF;
    chk("dump_entry_cpu_rst", if_a.cpu_rst_o, 1'b1);
    chk("dump_entry_valid", if_a.dump_valid_o, 1'b0);
    step();
    idle_a();
    chk("dump_first_valid", if_a.dump_valid_o, 1'b1);

    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), ref_a[i]});
    hs  = 0;
    cyc = 0;
    tog = 1'b1;
    while (hs < 4 && cyc < 40) begin
      if_a.dump_ready_i = tog;
      tog = ~tog;
      v   = if_a.dump_valid_o;
      rdy = if_a.dump_ready_i;
      a   = if_a.dump_addr_o;
      d   = if_a.dump_data_o;
      step();
      cyc++;
      if (v && rdy) begin
        e = exp_q.pop_front();
        chk("dump_addr", a, e[23:16]);
        chk("dump_data", d, e[15:0]);
        hs++;
        if (hs < 4) chk("dump_b2b_valid", if_a.dump_valid_o, 1'b1);
      end else if (v) begin
        chk("stall_valid", if_a.dump_valid_o, 1'b1);
        chk("stall_addr", if_a.dump_addr_o, a);
        chk("stall_data", if_a.dump_data_o, d);
      end
    end
    chk("dump_handshakes", hs, 4);
    chk("done_valid_low", if_a.dump_valid_o, 1'b0);
    chk("done_flag", if_a.dump_done_o, 1'b1);
    chk("done_cpu_rst", if_a.cpu_rst_o, 1'b1);
    if_a.dump_ready_i = 1'b1;
    repeat (3) step();
    chk("done_hold", if_a.dump_done_o, 1'b1);
    chk("done_hold_valid", if_a.dump_valid_o, 1'b0);
    idle_a();

    // reset mid-load: partial image stays, pointer restarts
    rst_a = 1'b1;
    step();
    chk("rst2_err", if_a.err_o, 1'b0);
    chk("rst2_done", if_a.dump_done_o, 1'b0);
    chk("rst2_mem_value", if_a.mem_value_o, 16'h0);
    rst_a   = 1'b0;
    lptr_a  = 8'd0;
    exp_val = 16'h0;
    exp_err = 1'b0;
    step();
    load_a(16'hAAAA, 1'b0);
    load_a(16'hBBBB, 1'b0);
    rst_a = 1'b1;
    step();
    rst_a  = 1'b0;
    lptr_a = 8'd0;
    step();
    chk("rst3_cpu_rst", if_a.cpu_rst_o, 1'b1);
    load_a(16'h7777, 1'b1);
    chk("reload_run", if_a.cpu_rst_o, 1'b0);
    cpu_op(1, 1, 0, 8'd0, 16'h0);
    chk("reload_mem0", if_a.mem_value_o, 16'h7777);
    cpu_op(1, 1, 0, 8'd1, 16'h0);
    chk("reload_mem1_old", if_a.mem_value_o, 16'hBBBB);
    cpu_op(1, 1, 0, 8'd5, 16'h0);
    chk("reload_mem5_kept", if_a.mem_value_o, 16'hBEEF);
    idle_a();
    chk("load_a_timeouts", to_a, 0);

    // ---------- instance B: full load, dump window wrapping at the top ----------
    rst_b = 1'b0;
    step();
    chk("b_load_ready", if_b.load_ready_o, 1'b1);
    if_b.load_valid_i = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ref_b[i] = 16'($urandom);
      if_b.load_data_i = ref_b[i];
      w = 0;
      while (!if_b.load_ready_o && w < 20) begin
        step();
        w++;
      end
      if (w >= 20) to_b++;
      if (i == 255) chk("b_cpu_rst_before_top", if_b.cpu_rst_o, 1'b1);
      step();
    end
    if_b.load_data_i = 16'hFFFF;
    chk("b_top_exit_cpu_rst", if_b.cpu_rst_o, 1'b0);
    chk("b_top_exit_ready", if_b.load_ready_o, 1'b0);
    chk("b_load_timeouts", to_b, 0);
    step();
    if_b.load_valid_i = 1'b0;

    if_b.end_program_i = 1'b1;
    step();
    if_b.end_program_i = 1'b0;
    chk("b_dump_entry_valid", if_b.dump_valid_o, 1'b0);
    if_b.dump_ready_i = 1'b1;
    step();
    exp_q.delete();
    exp_q.push_back({8'd254, ref_b[254]});
    exp_q.push_back({8'd255, ref_b[255]});
    exp_q.push_back({8'd0,   ref_b[0]});
    exp_q.push_back({8'd1,   ref_b[1]});
    hs  = 0;
    cyc = 0;
    while (hs < 4 && cyc < 20) begin
      v = if_b.dump_valid_o;
      a = if_b.dump_addr_o;
      d = if_b.dump_data_o;
      step();
      cyc++;
      if (v) begin
        e = exp_q.pop_front();
        chk("b_dump_addr", a, e[23:16]);
        chk("b_dump_data", d, e[15:0]);
        hs++;
        if (hs < 4) chk("b_b2b_valid", if_b.dump_valid_o, 1'b1);
      end
    end
    chk("b_dump_handshakes", hs, 4);
    chk("b_done", if_b.dump_done_o, 1'b1);
    chk("b_done_valid", if_b.dump_valid_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
